// File: rtl/j_pit_timer.sv
// j_pit_timer: prescaled interval timer with periodic tick/irq pulses and live count readback
module j_pit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             resl,
  input  logic             pre_wr,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] pre_cnt,
  output logic [WIDTH-1:0] div_cnt,
  output logic             run,
  output logic             tick,
  output logic             irq
);
  logic [WIDTH-1:0] pre_reload, div_reload, pre_reload_d, div_reload_d, pre_cnt_d, div_cnt_d;
  logic pre_exp, div_exp;
  assign run = |div_reload;
  // any write in a cycle masks expiry, so a write always beats counting
  always_comb begin
    pre_exp = run && pre_cnt == '0 && !(pre_wr || div_wr);
    div_exp = pre_exp && div_cnt == '0;
    pre_reload_d = pre_wr ? wr_data : pre_reload;
    div_reload_d = div_wr ? wr_data : div_reload;
    pre_cnt_d = pre_wr ? wr_data : (div_wr || pre_exp) ? pre_reload : run ? pre_cnt - WIDTH'(1) : pre_cnt;
    div_cnt_d = div_wr ? wr_data : !pre_exp ? div_cnt : div_exp ? div_reload : div_cnt - WIDTH'(1);
  end
  always_ff @(posedge sys_clk or negedge resl) begin
    if (!resl) begin
      pre_reload <= '0;
      div_reload <= '0;
      pre_cnt <= '0;
      div_cnt <= '0;
      tick <= 1'b0;
      irq <= 1'b0;
    end else begin
      pre_reload <= pre_reload_d;
      div_reload <= div_reload_d;
      pre_cnt <= pre_cnt_d;
      div_cnt <= div_cnt_d;
      tick <= pre_exp;
      irq <= div_exp;
    end
  end
endmodule

// File: tb/tb_j_pit_timer.sv
// tb_j_pit_timer: arithmetic period model checked every cycle, plus directed literal expectations
module tb_j_pit_timer;
  logic sys_clk = 0, resl = 0, pre_wr = 0, div_wr = 0;
  logic [15:0] wr_data = 0;
  logic [15:0] pre_cnt, div_cnt;
  logic run, tick, irq;
  logic s_pre_wr = 0, s_div_wr = 0;
  logic [7:0] s_wr_data = 0, s_pre_cnt, s_div_cnt;
  logic s_run, s_tick, s_irq;
  int checks = 0, errors = 0;
  longint mp0 = 0, md0 = 0, mP = 0, mD = 0, mn = 0;
  logic [33:0] seq_tbl [5] = '{{16'd1, 16'd1, 1'b0, 1'b0}, {16'd0, 16'd1, 1'b0, 1'b0},
                               {16'd1, 16'd0, 1'b1, 1'b0}, {16'd0, 16'd0, 1'b0, 1'b0},
                               {16'd1, 16'd1, 1'b1, 1'b1}};

  j_pit_timer #(.WIDTH(16)) dut (.sys_clk(sys_clk), .resl(resl), .pre_wr(pre_wr), .div_wr(div_wr),
    .wr_data(wr_data), .pre_cnt(pre_cnt), .div_cnt(div_cnt), .run(run), .tick(tick), .irq(irq));
  j_pit_timer #(.WIDTH(8)) u_small (.sys_clk(sys_clk), .resl(resl), .pre_wr(s_pre_wr), .div_wr(s_div_wr),
    .wr_data(s_wr_data), .pre_cnt(s_pre_cnt), .div_cnt(s_div_cnt), .run(s_run), .tick(s_tick), .irq(s_irq));

  always #5 sys_clk = ~sys_clk;

  // Model: n edges elapsed since the last load; counts follow from periods alone
  function automatic longint m_ticks(longint n);
    return n > mp0 ? (n - mp0 - 1) / (mP + 1) + 1 : 0;
  endfunction
  function automatic longint m_pre(longint n);
    return n <= mp0 ? mp0 - n : mP - ((n - mp0 - 1) % (mP + 1));
  endfunction
  function automatic logic m_tick(longint n);
    return n > mp0 && (n - mp0 - 1) % (mP + 1) == 0;
  endfunction
  function automatic longint m_div(longint n);
    longint t = m_ticks(n);
    return t <= md0 ? md0 - t : mD - ((t - md0 - 1) % (mD + 1));
  endfunction
  function automatic logic m_irq(longint n);
    longint t = m_ticks(n);
    return m_tick(n) && t > md0 && (t - md0 - 1) % (mD + 1) == 0;
  endfunction

  always @(posedge sys_clk or negedge resl)
    if (!resl) begin
      mp0 <= 0; md0 <= 0; mP <= 0; mD <= 0; mn <= 0;
    end else if (pre_wr || div_wr) begin
      mP <= pre_wr ? longint'(wr_data) : mP;
      mD <= div_wr ? longint'(wr_data) : mD;
      mp0 <= pre_wr ? longint'(wr_data) : mP;
      md0 <= div_wr ? longint'(wr_data) : m_div(mn);
      mn <= 0;
    end else if (mD != 0) mn <= mn + 1;

  always @(negedge sys_clk) begin
    checks++;
    if ({run, tick, irq, pre_cnt, div_cnt} !== {mD != 0, m_tick(mn), m_irq(mn), 16'(m_pre(mn)), 16'(m_div(mn))}) begin
      errors++;
      $display("FAIL model t=%0t got run=%b tick=%b irq=%b pre=%h div=%h, expected run=%b tick=%b irq=%b pre=%h div=%h",
        $time, run, tick, irq, pre_cnt, div_cnt, mD != 0, m_tick(mn), m_irq(mn), 16'(m_pre(mn)), 16'(m_div(mn)));
    end
  end

  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wr(logic p, logic d, logic [15:0] v);
    @(negedge sys_clk);
    pre_wr = p; div_wr = d; wr_data = v;
    @(negedge sys_clk);
    pre_wr = 0; div_wr = 0;
  endtask

  initial begin
    int k, nt;
    #12;
    chk("reset_state", {run, tick, irq, pre_cnt, div_cnt}, 0);
    @(negedge sys_clk); #2 resl = 1;
    wr(1, 0, 1); wr(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge sys_clk);
      chk($sformatf("seq%0d", i), {pre_cnt, div_cnt, tick, irq}, seq_tbl[i]);
    end
    repeat (4) @(negedge sys_clk);
    chk("irq_repeat", irq, 1);
    wr(1, 0, 0); wr(0, 1, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("p0_tick", tick, 1);
      chk("p0_div", div_cnt, 3 - ((i + 1) % 4));
      chk("p0_irq", irq, i % 4 == 3);
    end
    wr(1, 0, 2); wr(0, 1, 5);
    repeat (4) @(negedge sys_clk);
    wr(0, 1, 0);
    chk("stop", {run, pre_cnt, div_cnt}, {1'b0, 16'd2, 16'd0});
    nt = 0;
    repeat (50) begin @(negedge sys_clk); nt += int'(irq); end
    chk("stop_irq", nt, 0);
    chk("stop_frozen", {pre_cnt, div_cnt}, {16'd2, 16'd0});
    wr(1, 0, 3); wr(0, 1, 2);
    k = 0;
    while (pre_cnt != 0 && k < 10) begin @(negedge sys_clk); k++; end
    chk("coll_wait", k < 10, 1);
    pre_wr = 1; wr_data = 7;
    @(negedge sys_clk);
    pre_wr = 0;
    chk("coll", {tick, irq, pre_cnt}, {1'b0, 1'b0, 16'd7});
    wr(1, 1, 5);
    chk("both5", {pre_cnt, div_cnt}, {16'd5, 16'd5});
    k = 0;
    while (!irq && k < 100) begin @(negedge sys_clk); k++; end
    chk("both5_irq", k, 36);
    wr(1, 0, 3); wr(0, 1, 2);
    repeat (5) @(negedge sys_clk);
    #2 resl = 0;
    #1 chk("async_reset", {run, tick, irq, pre_cnt, div_cnt}, 0);
    @(negedge sys_clk); #2 resl = 1;
    nt = 0;
    repeat (100) begin @(negedge sys_clk); nt += int'(tick) + int'(irq); end
    chk("post_reset", nt, 0);
    wr(1, 0, 16'hFFFF); wr(0, 1, 1);
    chk("max_load", {pre_cnt, div_cnt}, {16'hFFFF, 16'd1});
    repeat (1000) @(negedge sys_clk);
    chk("max_count", pre_cnt, 16'hFC17);
    @(negedge sys_clk);
    s_pre_wr = 1; s_wr_data = 8'hFF;
    @(negedge sys_clk);
    s_pre_wr = 0; s_div_wr = 1; s_wr_data = 8'd1;
    @(negedge sys_clk);
    s_div_wr = 0;
    chk("small_load", {s_pre_cnt, s_div_cnt}, {8'hFF, 8'd1});
    k = 0; nt = 0;
    while (!s_irq && k < 600) begin @(negedge sys_clk); k++; nt += int'(s_tick); end
    chk("small_irq", k, 512);
    chk("small_ticks", nt, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
